// File: rtl/spi_master_ctrl_if.sv
// Handshake and SPI-side signal bundle for the SPI master sequencing controller.
// The master modport is the controller's view; slave is the requester/datapath side.
interface spi_master_ctrl_if #(
  parameter int DATA_W = 8
) ();
  logic              start;
  logic              abort;
  logic              miso;
  logic              ready;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              sclk;
  logic              cs_n;
  logic              sh_load;
  logic              sh_en;

  modport master (
    input  start, abort, miso,
    output ready, busy, done, rx_data, sclk, cs_n, sh_load, sh_en
  );

  modport slave (
    output start, abort, miso,
    input  ready, busy, done, rx_data, sclk, cs_n, sh_load, sh_en
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master sequencing controller (mode 0). Generates sclk/cs_n, strobes the TX
// shift datapath (load once, then one shift per bit except the last) and gathers
// MISO bits MSB-first into rx_data. Every output is a register decoded from the
// next state, so outputs line up with the state they describe.
module spi_master_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8,
  parameter int CS_IDLE = 2
) (
  input  logic clk,
  input  logic rst,
  spi_master_ctrl_if.master bus
);

  // A zero-length gap would collide with the done cycle, so at least one
  // half-period of cs_n-high time is always kept.
  localparam int GAP_HALVES = (CS_IDLE > 1) ? CS_IDLE : 1;
  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(DATA_W);
  localparam int GW = (GAP_HALVES > 1) ? $clog2(GAP_HALVES) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_HALVES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, HIGH, LOW, GAP} state_t;

  state_t            state, state_nxt;
  logic [HW-1:0]     half_cnt, half_cnt_nxt;
  logic [BW-1:0]     bit_cnt, bit_cnt_nxt;
  logic [GW-1:0]     gap_cnt, gap_cnt_nxt;
  logic [DATA_W-1:0] rx_shift;
  logic              half_end;
  logic              capture;
  logic              finish;
  logic              shift_pulse;

  // Next-state logic; LOAD counts as the first cycle of the sclk-low setup period.
  always_comb begin
    state_nxt    = state;
    half_cnt_nxt = half_cnt;
    bit_cnt_nxt  = bit_cnt;
    gap_cnt_nxt  = gap_cnt;
    capture      = 1'b0;
    finish       = 1'b0;
    shift_pulse  = 1'b0;
    half_end     = (half_cnt == HALF_LAST);

    if (bus.abort && (state inside {LOAD, SETUP, HIGH, LOW})) begin
      state_nxt    = GAP;
      half_cnt_nxt = '0;
      gap_cnt_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state_nxt    = LOAD;
            half_cnt_nxt = '0;
            bit_cnt_nxt  = '0;
          end
        end
        LOAD, SETUP: begin
          if (half_end) begin
            state_nxt    = HIGH;
            half_cnt_nxt = '0;
            capture      = 1'b1;
          end else begin
            state_nxt    = SETUP;
            half_cnt_nxt = half_cnt + 1'b1;
          end
        end
        HIGH: begin
          if (half_end) begin
            state_nxt    = LOW;
            half_cnt_nxt = '0;
            shift_pulse  = (bit_cnt != BIT_LAST);
          end else begin
            half_cnt_nxt = half_cnt + 1'b1;
          end
        end
        LOW: begin
          if (half_end) begin
            half_cnt_nxt = '0;
            if (bit_cnt == BIT_LAST) begin
              state_nxt   = GAP;
              gap_cnt_nxt = '0;
              finish      = 1'b1;
            end else begin
              state_nxt   = HIGH;
              bit_cnt_nxt = bit_cnt + 1'b1;
              capture     = 1'b1;
            end
          end else begin
            half_cnt_nxt = half_cnt + 1'b1;
          end
        end
        GAP: begin
          if (half_end) begin
            half_cnt_nxt = '0;
            if (gap_cnt == GAP_LAST) begin
              state_nxt = IDLE;
            end else begin
              gap_cnt_nxt = gap_cnt + 1'b1;
            end
          end else begin
            half_cnt_nxt = half_cnt + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, counters, receive shifter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      half_cnt    <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      rx_shift    <= '0;
      bus.rx_data <= '0;
      bus.ready   <= 1'b1;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.sclk    <= 1'b0;
      bus.cs_n    <= 1'b1;
      bus.sh_load <= 1'b0;
      bus.sh_en   <= 1'b0;
    end else begin
      state    <= state_nxt;
      half_cnt <= half_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      gap_cnt  <= gap_cnt_nxt;
      if (capture) begin
        rx_shift <= {rx_shift[DATA_W-2:0], bus.miso};
      end
      if (finish) begin
        bus.rx_data <= rx_shift;
      end
      bus.ready   <= (state_nxt == IDLE);
      bus.busy    <= (state_nxt != IDLE);
      bus.done    <= finish;
      bus.sclk    <= (state_nxt == HIGH);
      bus.cs_n    <= !(state_nxt inside {LOAD, SETUP, HIGH, LOW});
      bus.sh_load <= (state_nxt == LOAD);
      bus.sh_en   <= shift_pulse;
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed self-checking bench for spi_master_ctrl: one instance with CLK_DIV=1
// and one with CLK_DIV=3, both DATA_W=8, CS_IDLE=2. Cycle n is the value seen at
// the falling edge after rising edge T(n-1), where T0 samples start.
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  spi_master_ctrl_if #(.DATA_W(8)) a_if ();
  spi_master_ctrl_if #(.DATA_W(8)) b_if ();

  spi_master_ctrl #(.CLK_DIV(1), .DATA_W(8), .CS_IDLE(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  spi_master_ctrl #(.CLK_DIV(3), .DATA_W(8), .CS_IDLE(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  // Free-running system clock, period 10.
  always #5 clk = ~clk;

  // Slave model for instance a: presents pattern bit 7-idx, advancing after each sclk rise.
  logic [7:0] pat_a;
  logic [7:0] sh_a;
  logic [3:0] idx_a = '0;
  logic       prev_a = 1'b0;
  always @(negedge clk) begin
    if (a_if.cs_n) idx_a = '0;
    else if (a_if.sclk && !prev_a) idx_a = idx_a + 4'd1;
    prev_a = a_if.sclk;
  end
  assign sh_a      = pat_a << idx_a;
  assign a_if.miso = sh_a[7];
  assign b_if.miso = 1'b1;

  task automatic checkOutput(input string tag, input int n, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s n=%0d observed=%b expected=%b", tag, n, obs, exp);
    end
  endtask

  task automatic checkWord(input string tag, input int n, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s n=%0d observed=0x%0h expected=0x%0h", tag, n, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a);
    @(negedge clk);
    a_if.start = s;
    a_if.abort = a;
  endtask

  initial begin
    rst        = 1'b1;
    a_if.start = 1'b0;
    a_if.abort = 1'b0;
    b_if.start = 1'b0;
    b_if.abort = 1'b0;
    pat_a      = 8'hB2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", 0, a_if.ready, 1'b1);
    checkOutput("rst_busy", 0, a_if.busy, 1'b0);
    checkOutput("rst_done", 0, a_if.done, 1'b0);
    checkOutput("rst_sclk", 0, a_if.sclk, 1'b0);
    checkOutput("rst_cs_n", 0, a_if.cs_n, 1'b1);
    checkOutput("rst_sh_load", 0, a_if.sh_load, 1'b0);
    checkOutput("rst_sh_en", 0, a_if.sh_en, 1'b0);
    checkWord("rst_rx_data", 0, a_if.rx_data, 8'h00);
    checkOutput("rst_b_ready", 0, b_if.ready, 1'b1);
    rst = 1'b0;

    $display("[TB] frame CLK_DIV=1 pattern 0xB2");
    applyStimulus(1'b1, 1'b0);
    @(posedge clk);
    #1 a_if.start = 1'b0;
    for (int n = 1; n <= 21; n++) begin
      @(negedge clk);
      checkOutput("t1_sh_load", n, a_if.sh_load, n == 1);
      checkOutput("t1_sclk", n, a_if.sclk, (n >= 2 && n <= 16 && n % 2 == 0));
      checkOutput("t1_sh_en", n, a_if.sh_en, (n >= 3 && n <= 15 && n % 2 == 1));
      checkOutput("t1_done", n, a_if.done, n == 18);
      checkOutput("t1_cs_n", n, a_if.cs_n, !(n >= 1 && n <= 17));
      checkOutput("t1_ready", n, a_if.ready, n >= 20);
      checkOutput("t1_busy", n, a_if.busy, n < 20);
      checkWord("t1_rx_data", n, a_if.rx_data, (n >= 18) ? 8'hB2 : 8'h00);
    end

    $display("[TB] frame CLK_DIV=3 miso held high");
    @(negedge clk);
    b_if.start = 1'b1;
    @(posedge clk);
    #1 b_if.start = 1'b0;
    for (int n = 1; n <= 58; n++) begin
      @(negedge clk);
      checkOutput("t2_sclk", n, b_if.sclk, (n >= 4 && n <= 51 && ((n - 4) / 3) % 2 == 0));
      checkOutput("t2_sh_en", n, b_if.sh_en, (n >= 7 && n <= 43 && (n - 7) % 6 == 0));
      checkOutput("t2_done", n, b_if.done, n == 52);
      checkOutput("t2_ready", n, b_if.ready, n >= 58);
      checkWord("t2_rx_data", n, b_if.rx_data, (n >= 52) ? 8'hFF : 8'h00);
    end

    $display("[TB] start held continuously");
    applyStimulus(1'b1, 1'b0);
    @(posedge clk);
    for (int n = 1; n <= 21; n++) begin
      @(negedge clk);
      checkOutput("t3_sh_load", n, a_if.sh_load, (n == 1 || n == 21));
      checkOutput("t3_ready", n, a_if.ready, n == 20);
    end
    a_if.start = 1'b0;
    begin
      int waited = 0;
      while (!a_if.ready && waited < 40) begin
        @(negedge clk);
        waited++;
      end
      checkOutput("t3_ready_timeout", waited, a_if.ready, 1'b1);
      checkWord("t3_rx_data", waited, a_if.rx_data, 8'hB2);
    end

    $display("[TB] abort at third sclk rise");
    applyStimulus(1'b1, 1'b0);
    @(posedge clk);
    #1 a_if.start = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 6) begin
        checkOutput("t4_sclk_before", n, a_if.sclk, 1'b1);
        a_if.abort = 1'b1;
      end
      if (n >= 7) begin
        a_if.abort = 1'b0;
        checkOutput("t4_sclk", n, a_if.sclk, 1'b0);
        checkOutput("t4_cs_n", n, a_if.cs_n, 1'b1);
        checkOutput("t4_sh_en", n, a_if.sh_en, 1'b0);
        checkOutput("t4_done", n, a_if.done, 1'b0);
        checkOutput("t4_ready", n, a_if.ready, n >= 9);
        checkWord("t4_rx_data", n, a_if.rx_data, 8'hB2);
      end
    end

    $display("[TB] start and abort together in idle");
    applyStimulus(1'b1, 1'b1);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      checkOutput("t6_ready", n, a_if.ready, 1'b1);
      checkOutput("t6_sh_load", n, a_if.sh_load, 1'b0);
      checkOutput("t6_cs_n", n, a_if.cs_n, 1'b1);
    end
    a_if.start = 1'b0;
    a_if.abort = 1'b0;

    $display("[TB] reset mid-frame then fresh frame 0x5A");
    applyStimulus(1'b1, 1'b0);
    @(posedge clk);
    #1 a_if.start = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (n == 8) rst = 1'b1;
      if (n == 9) begin
        checkOutput("t5_ready", n, a_if.ready, 1'b1);
        checkOutput("t5_busy", n, a_if.busy, 1'b0);
        checkOutput("t5_done", n, a_if.done, 1'b0);
        checkOutput("t5_sclk", n, a_if.sclk, 1'b0);
        checkOutput("t5_cs_n", n, a_if.cs_n, 1'b1);
        checkOutput("t5_sh_load", n, a_if.sh_load, 1'b0);
        checkOutput("t5_sh_en", n, a_if.sh_en, 1'b0);
        checkWord("t5_rx_data", n, a_if.rx_data, 8'h00);
        rst = 1'b0;
      end
    end
    pat_a = 8'h5A;
    applyStimulus(1'b1, 1'b0);
    @(posedge clk);
    #1 a_if.start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      checkOutput("t5b_done", n, a_if.done, n == 18);
      checkOutput("t5b_ready", n, a_if.ready, n >= 20);
      checkWord("t5b_rx_data", n, a_if.rx_data, (n >= 18) ? 8'h5A : 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
Sequencing controller for the SPI master shift datapath. It accepts a transfer request and generates SCLK (mode 0: CPOL=0, CPHA=0) and chip select. It issues the load and shift strobes to the TX shift register and assembles received MISO bits into a parallel word. MOSI comes straight from the shift datapath's serial output; this block does not drive MOSI.

Parameters:
CLK_DIV, 4, system clk cycles per SCLK half-period; legal range >= 1
DATA_W, 8, bits per frame; legal range >= 2
CS_IDLE, 2, minimum cs_n-high gap after a frame, in SCLK half-periods

Ports:
clk  in  1  system clock; every register updates on its rising edge
rst  in  1  synchronous reset, active-high
start  in  1  transfer request; accepted only in a cycle where ready=1
abort  in  1  terminate the current frame immediately
miso  in  1  serial data from the slave
ready  out  1  high when idle and able to accept start
busy  out  1  high from the cycle after acceptance until ready returns; always equals ~ready
done  out  1  one-cycle pulse at the end of a completed frame
rx_data  out  DATA_W  last completed received word, MSB first on the wire
sclk  out  1  SPI clock; idles low
cs_n  out  1  chip select, active-low
sh_load  out  1  one-cycle strobe to the shift datapath load input
sh_en  out  1  one-cycle strobe to the shift datapath shift_en input

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: ready=1, busy=0, done=0, rx_data=0, sclk=0, cs_n=1, sh_load=0, sh_en=0. All state returns to IDLE.
- All outputs are registered.
- States: IDLE, LOAD, SETUP, HIGH, LOW, GAP. A half-period counter counts 0..CLK_DIV-1. A bit counter counts 0..DATA_W-1.
- Timing is given relative to T0, the rising edge at which start=1 and ready=1 are sampled.
- Acceptance:
  - ready drops in T0+1.
  - LOAD occupies T0+1: sh_load=1 and cs_n=0 from this cycle on.
- SETUP: lasts CLK_DIV cycles with sclk=0.
- Bit k, for k = 0..DATA_W-1:
  - sclk rises at T0+1+CLK_DIV+2k·CLK_DIV and stays high for CLK_DIV cycles (HIGH).
  - At the edge where sclk goes 0->1, miso is shifted into rx_shift LSB-side: rx_shift <= {rx_shift[DATA_W-2:0], miso}.
  - sclk then falls and stays low for CLK_DIV cycles (LOW).
  - sh_en=1 for exactly the first cycle of LOW for k = 0..DATA_W-2. There is no sh_en after the last bit.
  - Total sh_en pulses per frame: DATA_W-1.
- End of frame, at T0+1+CLK_DIV+2·DATA_W·CLK_DIV (call it Te):
  - cs_n=1 and done=1 for one cycle.
  - rx_data <= rx_shift, updated in the same cycle done is high.
  - Enter GAP.
- GAP: lasts CS_IDLE·CLK_DIV cycles, then IDLE; ready=1 again at Te+CS_IDLE·CLK_DIV.
- rx_data holds its value until the next completed frame. It is never altered by abort.
- start while ready=0 is ignored and is not queued.
- abort:
  - Sampled high in any state other than IDLE or GAP: the next cycle gives sclk=0, cs_n=1, sh_en=0, sh_load=0, and the block enters GAP. done is not pulsed.
  - In GAP or IDLE: no effect.
  - abort and start together in IDLE: abort wins and start is ignored.
- rst during a frame: on the next edge, all outputs take their reset values. There is no done pulse, and rx_data returns to 0.
- sclk is never high while cs_n=1.
- sh_load and sh_en are never high in the same cycle.

Test Plan:
- CLK_DIV=1, DATA_W=8, CS_IDLE=2, start at T0, miso driven 1,0,1,1,0,0,1,0 on successive rising half-periods:
  - sh_load at T1; sclk rises at T2,T4,…,T16; sh_en at T3,T5,…,T15 (7 pulses).
  - done at T18 with rx_data=0xB2 and cs_n=1; ready at T20.
- CLK_DIV=3, DATA_W=8, miso held 1:
  - each sclk high and low phase lasts 3 cycles; first rise at T4; done at T0+52 with rx_data=0xFF.
- start asserted continuously: second frame's sh_load appears exactly one cycle after ready rises. No start is accepted while busy.
- abort at sclk's 3rd rising edge (CLK_DIV=1):
  - next cycle sclk=0 and cs_n=1, with no done.
  - rx_data keeps its previous value.
  - ready returns 2 cycles later.
- rst asserted mid-frame: all outputs at reset values on the next edge, rx_data=0, and a fresh start completes normally.
- start=1 and abort=1 together in IDLE: ready stays 1, and no sh_load or cs_n activity follows.
